// File: rtl/switch_press_counter_pkg.sv
// Shared types and constants for the switch press counter: FSM states, BCD digit
// type, active-low seven-segment patterns (bit 6 = A ... bit 0 = G) and BCD helpers.
package press_counter_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    localparam bcd_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input bcd_t digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Two-digit decimal increment; 99 rolls over to 00 silently.
    function automatic bcd_pair_t bcd_pair_inc(input bcd_pair_t value);
        bcd_pair_t result;
        result = value;
        if (value.ones == BCD_MAX) begin
            result.ones = '0;
            result.tens = (value.tens == BCD_MAX) ? bcd_t'(0) : value.tens + 4'd1;
        end else begin
            result.ones = value.ones + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_press_counter_if.sv
// Signal bundle between the press counter and its environment: the debounced
// switch level in, count digits, segment patterns and event pulses out.
interface switch_press_counter_if;
    import press_counter_pkg::*;

    logic       i_Switch;
    bcd_t       o_Count_Ones;
    bcd_t       o_Count_Tens;
    logic [6:0] o_Seg_Ones;
    logic [6:0] o_Seg_Tens;
    logic       o_Count_Pulse;
    logic       o_Clear_Pulse;

    modport master (
        output i_Switch,
        input  o_Count_Ones,
        input  o_Count_Tens,
        input  o_Seg_Ones,
        input  o_Seg_Tens,
        input  o_Count_Pulse,
        input  o_Clear_Pulse
    );

    modport slave (
        input  i_Switch,
        output o_Count_Ones,
        output o_Count_Tens,
        output o_Seg_Ones,
        output o_Seg_Tens,
        output o_Count_Pulse,
        output o_Clear_Pulse
    );

endinterface

// File: rtl/switch_press_counter_bcd_to_7seg.sv
// Registered BCD to active-low seven-segment decode; resets to the "0" pattern,
// codes 10-15 blank the digit.
module bcd_to_7seg
    import press_counter_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  bcd_t       i_Digit,
    output logic [6:0] o_Seg
);

    logic [6:0] seg_q;
    logic [6:0] seg_d;

    always_comb begin
        seg_d = bcd_to_seg(i_Digit);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            seg_q <= SEG_0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign o_Seg = seg_q;

endmodule

// File: rtl/switch_press_counter.sv
// Counts releases of a debounced switch as 00-99 BCD and drives two segment digits.
// Optional long-press clear is enabled by defining PRESS_COUNTER_HOLD_CLEAR_EN.
module switch_press_counter
    import press_counter_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    switch_press_counter_if.slave  bus
);

    if (HOLD_CYCLES < 2) begin : g_hold_check
        $error("HOLD_CYCLES must be at least 2");
    end

    logic      switch_q;
    logic      rise;
    logic      fall;
    state_e    state_q;
    state_e    state_d;
    bcd_pair_t count_q;
    bcd_pair_t count_d;
    logic      count_pulse_q;
    logic      count_pulse_d;

`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
    localparam int              HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              clear_pulse_q;
    logic              clear_pulse_d;
`endif

    // switch_q starts at 0 after reset, so a switch held through reset is seen as a new press.
    assign rise = bus.i_Switch & ~switch_q;
    assign fall = ~bus.i_Switch & switch_q;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        count_pulse_d = 1'b0;
`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
        hold_d        = hold_q;
        clear_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
                    hold_d  = '0;
`endif
                end
            end
            PRESSED: begin
                // A release on the threshold cycle still counts: fall is tested first.
                if (fall) begin
                    count_d       = bcd_pair_inc(count_q);
                    count_pulse_d = 1'b1;
                    state_d       = IDLE;
                end
`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
                else if (hold_q == HOLD_LAST) begin
                    count_d       = '0;
                    clear_pulse_d = 1'b1;
                    state_d       = HELD;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            switch_q      <= 1'b0;
            state_q       <= IDLE;
            count_q       <= '0;
            count_pulse_q <= 1'b0;
        end else begin
            switch_q      <= bus.i_Switch;
            state_q       <= state_d;
            count_q       <= count_d;
            count_pulse_q <= count_pulse_d;
        end
    end

`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            hold_q        <= '0;
            clear_pulse_q <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            clear_pulse_q <= clear_pulse_d;
        end
    end

    assign bus.o_Clear_Pulse = clear_pulse_q;
`else
    assign bus.o_Clear_Pulse = 1'b0;
`endif

    assign bus.o_Count_Ones  = count_q.ones;
    assign bus.o_Count_Tens  = count_q.tens;
    assign bus.o_Count_Pulse = count_pulse_q;

    // Index 0 decodes the ones digit, index 1 the tens digit.
    bcd_t       digit_w [2];
    logic [6:0] seg_w   [2];

    assign digit_w[0] = count_q.ones;
    assign digit_w[1] = count_q.tens;

    for (genvar gi = 0; gi < 2; gi++) begin : g_seg
        bcd_to_7seg u_dec (
            .i_Clk   (i_Clk),
            .i_Rst_L (i_Rst_L),
            .i_Digit (digit_w[gi]),
            .o_Seg   (seg_w[gi])
        );
    end

    assign bus.o_Seg_Ones = seg_w[0];
    assign bus.o_Seg_Tens = seg_w[1];

endmodule

// File: tb/tb_switch_press_counter.sv
// Self-checking bench for switch_press_counter: directed scenarios plus random presses,
// compared every cycle against a behavioural press/hold model.
module tb_switch_press_counter;

    localparam int HOLD = 8;
`ifdef PRESS_COUNTER_HOLD_CLEAR_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    switch_press_counter_if bus ();

    switch_press_counter #(.HOLD_CYCLES(HOLD)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    int n_vec   = 0;
    int n_fail  = 0;
    int seen_cp = 0;
    int seen_clp = 0;

    // Model state: count as a plain integer, press age in clock edges since the rise edge.
    int m_count     = 0;
    int m_seg_count = 0;
    int m_age       = 0;
    bit m_prev      = 1'b0;
    bit m_pressing  = 1'b0;
    bit m_held      = 1'b0;
    bit m_cp        = 1'b0;
    bit m_clp       = 1'b0;
    bit m_valid     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit sw, input bit rn);
        if (!rn) begin
            m_count = 0; m_seg_count = 0; m_prev = 1'b0;
            m_pressing = 1'b0; m_held = 1'b0; m_cp = 1'b0; m_clp = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_seg_count = m_count;
            m_cp = 1'b0;
            m_clp = 1'b0;
            if (m_pressing) begin
                m_age++;
                if (!sw && m_prev) begin
                    m_count = (m_count + 1) % 100;
                    m_cp = 1'b1;
                    m_pressing = 1'b0;
                end else if (HOLD_EN && m_age == HOLD) begin
                    m_count = 0;
                    m_clp = 1'b1;
                    m_pressing = 1'b0;
                    m_held = 1'b1;
                end
            end else if (m_held) begin
                if (!sw && m_prev) m_held = 1'b0;
            end else if (sw && !m_prev) begin
                m_pressing = 1'b1;
                m_age = 0;
            end
            m_prev = sw;
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("count_ones",  bus.o_Count_Ones,  m_count % 10);
                chk("count_tens",  bus.o_Count_Tens,  m_count / 10);
                chk("seg_ones",    bus.o_Seg_Ones,    seg_tab[m_seg_count % 10]);
                chk("seg_tens",    bus.o_Seg_Tens,    seg_tab[m_seg_count / 10]);
                chk("count_pulse", bus.o_Count_Pulse, m_cp);
                chk("clear_pulse", bus.o_Clear_Pulse, m_clp);
                chk("pulse_excl",  bus.o_Count_Pulse & bus.o_Clear_Pulse, 0);
                if (bus.o_Count_Pulse === 1'b1) seen_cp++;
                if (bus.o_Clear_Pulse === 1'b1) seen_clp++;
            end
            model_step(bus.i_Switch, rst_n);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hi, input int lo);
        bus.i_Switch = 1'b1;
        tick(hi);
        bus.i_Switch = 1'b0;
        tick(lo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    int cp0;
    int clp0;

    initial begin
        bus.i_Switch = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        @(negedge clk);
        chk("rst_ones",  bus.o_Count_Ones, 0);
        chk("rst_tens",  bus.o_Count_Tens, 0);
        chk("rst_seg_o", bus.o_Seg_Ones, 7'b0000001);
        chk("rst_seg_t", bus.o_Seg_Tens, 7'b0000001);
        chk("rst_cp",    bus.o_Count_Pulse, 0);
        chk("rst_clp",   bus.o_Clear_Pulse, 0);

        // Five ordinary presses
        cp0 = seen_cp;
        tick(1);
        repeat (5) press(10, 4);
        chk("five_pulses", seen_cp - cp0, 5);
        chk("model_five", m_count, 5);
        @(negedge clk);
        chk("five_ones", bus.o_Count_Ones, 5);
        chk("five_seg",  bus.o_Seg_Ones, 7'b0100100);
        chk("five_tens", bus.o_Count_Tens, 0);

        // Preload to 99, then wrap
        tick(1);
        do_reset();
        repeat (99) press(2, 2);
        @(negedge clk);
        chk("n99_ones",  bus.o_Count_Ones, 9);
        chk("n99_tens",  bus.o_Count_Tens, 9);
        chk("n99_seg_o", bus.o_Seg_Ones, 7'b0000100);
        chk("n99_seg_t", bus.o_Seg_Tens, 7'b0000100);
        tick(1);
        cp0 = seen_cp;
        clp0 = seen_clp;
        press(2, 3);
        chk("wrap_cp",  seen_cp - cp0, 1);
        chk("wrap_clp", seen_clp - clp0, 0);
        @(negedge clk);
        chk("wrap_ones", bus.o_Count_Ones, 0);
        chk("wrap_tens", bus.o_Count_Tens, 0);
        chk("wrap_seg",  bus.o_Seg_Tens, 7'b0000001);

        // Long hold from 42: clear exactly HOLD edges after the rise edge
        tick(1);
        do_reset();
        repeat (42) press(2, 2);
        cp0 = seen_cp;
        clp0 = seen_clp;
        bus.i_Switch = 1'b1;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        chk("hold_pre_clear", bus.o_Clear_Pulse, 0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_clear_at", bus.o_Clear_Pulse, HOLD_EN);
        repeat (11) @(posedge clk);
        #1;
        bus.i_Switch = 1'b0;
        tick(4);
        chk("hold_cp",  seen_cp - cp0, HOLD_EN ? 0 : 1);
        chk("hold_clp", seen_clp - clp0, HOLD_EN ? 1 : 0);
        @(negedge clk);
        chk("hold_ones", bus.o_Count_Ones, HOLD_EN ? 0 : 3);
        chk("hold_tens", bus.o_Count_Tens, HOLD_EN ? 0 : 4);

        // Release on the threshold edge counts; one cycle longer clears
        tick(1);
        do_reset();
        repeat (3) press(2, 2);
        cp0 = seen_cp;
        clp0 = seen_clp;
        press(HOLD, 3);
        chk("thr_cp",  seen_cp - cp0, 1);
        chk("thr_clp", seen_clp - clp0, 0);
        @(negedge clk);
        chk("thr_ones", bus.o_Count_Ones, 4);
        tick(1);
        press(HOLD + 1, 3);
        @(negedge clk);
        chk("thr1_ones", bus.o_Count_Ones, HOLD_EN ? 0 : 5);

        // Reset while pressed with the switch still held
        tick(1);
        do_reset();
        repeat (7) press(2, 2);
        bus.i_Switch = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        @(negedge clk);
        chk("mid_rst_ones", bus.o_Count_Ones, 0);
        tick(1);
        bus.i_Switch = 1'b0;
        tick(3);
        @(negedge clk);
        chk("mid_rst_after", bus.o_Count_Ones, 1);

        // Random presses, gaps and occasional resets
        tick(1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            press($urandom_range(1, 12), $urandom_range(1, 5));
        end
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_press_counter.md
# switch_press_counter

Counts debounced switch presses and drives two seven-segment digits with the running count, 00–99 decimal. It sits directly downstream of the switch debounce filter and consumes its filtered level. A press counts on release, which is the falling edge of the debounced level. When hold-clear is compiled in, a long press clears the count instead.

## Interface
- `HOLD_CYCLES`, default 50_000_000 — hold duration in clock cycles before clear (2 s at 25 MHz); legal values ≥ 2.
- `i_Clk`  in  1  — system clock; all logic on rising edge.
- `i_Rst_L`  in  1  — reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- `i_Switch`  in  1  — debounced switch level from the debounce filter; 1 = pressed.
- `o_Count_Ones`  out  4  — BCD ones digit; reset 0.
- `o_Count_Tens`  out  4  — BCD tens digit; reset 0.
- `o_Seg_Ones`  out  7  — ones-digit segments, active-low, bit 6 = A … bit 0 = G; reset 7'b0000001 ("0").
- `o_Seg_Tens`  out  7  — tens-digit segments, same format; reset 7'b0000001.
- `o_Count_Pulse`  out  1  — one-cycle pulse when the count increments; reset 0.
- `o_Clear_Pulse`  out  1  — one-cycle pulse when hold-clear fires; reset 0.

## Operation
- `r_Switch` registers `i_Switch` every cycle and resets to 0.
  - rise = `i_Switch & ~r_Switch`
  - fall = `~i_Switch & r_Switch`
- FSM states: IDLE, PRESSED, HELD. Reset state is IDLE.
- IDLE:
  - on rise, go to PRESSED and zero the hold counter.
  - Level-high without a rise does not leave IDLE.
- PRESSED:
  - on fall, increment the count, pulse `o_Count_Pulse`, and go to IDLE.
  - otherwise, increment the hold counter.
  - when the hold counter reaches `HOLD_CYCLES-1`: clear both digits to 0, pulse `o_Clear_Pulse`, go to HELD.
- HELD: on fall, go to IDLE with no increment.
- Increment rule:
  - ones 0–8 → +1.
  - ones 9 → ones 0, tens +1.
  - 99 → 00 (wrap, no flag).
- Simultaneous fall and hold threshold in the same cycle: the fall wins. Increment, no clear.
- Hold counter width is `$clog2(HOLD_CYCLES)`. It saturates and never wraps.
- Reset mid-operation:
  - count is zeroed and FSM returns to IDLE.
  - `r_Switch` = 0, so a switch still held when reset deasserts produces a rise on the first cycle. It enters PRESSED and counts on release.
- Digits 0–9 map to the standard seven-segment patterns. Codes 10–15 cannot occur and map to all-off (7'b1111111).

## Timing
- Let edge k be the first clock edge that samples `i_Switch` low after it was high in PRESSED.
- Edge k updates `o_Count_*` and `o_Count_Pulse`; both are visible after k.
- Edge k+1 updates `o_Seg_*` (registered decode stage), one cycle behind the count.
- `o_Count_Pulse` and `o_Clear_Pulse` are high for exactly one cycle and are never high in the same cycle.
- Clear happens `HOLD_CYCLES` cycles after the edge that registered the rise.
- Segments follow the clear one cycle later.

## Configuration
- `PRESS_COUNTER_HOLD_CLEAR_EN` defined:
  - HELD state, hold counter and `o_Clear_Pulse` logic are present as described above.
- Not defined:
  - FSM is IDLE/PRESSED only and the hold counter is absent.
  - Every release increments, regardless of press length.
  - `o_Clear_Pulse` is tied to 0.
  - `HOLD_CYCLES` is ignored.

## Structure
- Package `press_counter_pkg` holds:
  - the FSM state enum (IDLE, PRESSED, HELD);
  - the 7-bit segment constants for digits 0–9 and blank;
  - the BCD digit typedef (4-bit).
- Sub-module `bcd_to_7seg` is a registered BCD-to-segment decode with synchronous active-low reset to the "0" pattern. It is instantiated twice, for ones and tens.

## Test plan
- Reset with `i_Switch` = 0, then release reset:
  - counts 0/0; `o_Seg_*` = 7'b0000001; both pulses 0.
- Five press/release pairs, each high for 10 cycles (`HOLD_CYCLES` = 8, macro off):
  - 5 `o_Count_Pulse`;
  - `o_Count_Ones` = 5, `o_Seg_Ones` = 7'b0100100;
  - tens 0.
- Preload to 99 via 99 presses, one more press:
  - counts 0/0, one `o_Count_Pulse`; no clear pulse.
- Macro on, `HOLD_CYCLES` = 8, count 42, hold `i_Switch` high for 20 cycles then release:
  - `o_Clear_Pulse` exactly 8 cycles after the rise-register edge;
  - count 00 and stays 00 after release; no `o_Count_Pulse`.
- Macro on, release on exactly the threshold cycle:
  - increment occurs, no clear.
- Assert `i_Rst_L` = 0 while in PRESSED with count 7, release reset with switch still high, then release the switch:
  - count 0 after reset, then 1 after the release.
